// File: rtl/burst_initiator.sv
//============================================================================
// Module      : burst_initiator
// Description : Single-slot AXI write-burst initiator. A header plus up to
//               MAX_LEN beats of data/strobe is captured into a slot, then
//               issued as one AW transfer, len+1 W beats and a B response.
//               Completion is reported with a one-cycle done pulse, with err
//               raised alongside it when the response is bad.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module burst_initiator #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 16
) (
    input  logic                                clk,
    input  logic                                rst,

    // Slot load
    input  logic                                ld_valid,
    output logic                                ld_ready,
    input  logic [ID_WIDTH+ADDR_WIDTH+11-1:0]   ld_hdr,
    input  logic [MAX_LEN*DATA_WIDTH-1:0]       ld_data,
    input  logic [MAX_LEN*DATA_WIDTH/8-1:0]     ld_strb,

    // AXI write address channel
    output logic                                awvalid,
    input  logic                                awready,
    output logic [ID_WIDTH-1:0]                 awid,
    output logic [ADDR_WIDTH-1:0]               awaddr,
    output logic [3:0]                          awlen,
    output logic [2:0]                          awsize,
    output logic [1:0]                          awburst,
    output logic [1:0]                          awuser,

    // AXI write data channel
    output logic                                wvalid,
    input  logic                                wready,
    output logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH/8-1:0]             wstrb,
    output logic                                wlast,

    // AXI write response channel
    input  logic                                bvalid,
    output logic                                bready,
    input  logic [ID_WIDTH-1:0]                 bid,
    input  logic [1:0]                          bresp,

    // Status
    output logic                                done,
    output logic                                err,
    output logic                                busy
);

    localparam int HDR_W     = ID_WIDTH + ADDR_WIDTH + 11;
    localparam int STRB_W    = DATA_WIDTH / 8;
    // Header field offsets; id sits in the least significant bits.
    localparam int ADDR_LSB  = ID_WIDTH;
    localparam int LEN_LSB   = ADDR_LSB + ADDR_WIDTH;
    localparam int SIZE_LSB  = LEN_LSB + 4;
    localparam int BURST_LSB = SIZE_LSB + 3;
    localparam int USER_LSB  = BURST_LSB + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                         state_q;
    logic [HDR_W-1:0]               hdr_q;
    logic [MAX_LEN*DATA_WIDTH-1:0]  data_q;
    logic [MAX_LEN*STRB_W-1:0]      strb_q;
    logic [3:0]                     cnt_q;
    logic                           awvalid_q;
    logic                           wvalid_q;
    logic                           bready_q;
    logic                           done_q;
    logic                           err_q;

    logic [ID_WIDTH-1:0]            slot_id;
    logic [3:0]                     slot_len;
    logic                           last_beat;
    logic [31:0]                    data_base;
    logic [31:0]                    strb_base;

    // Slot header fields as presented on the AW channel.
    assign slot_id   = hdr_q[ID_WIDTH-1:0];
    assign slot_len  = hdr_q[LEN_LSB +: 4];
    assign awid      = slot_id;
    assign awaddr    = hdr_q[ADDR_LSB +: ADDR_WIDTH];
    assign awlen     = slot_len;
    assign awsize    = hdr_q[SIZE_LSB +: 3];
    assign awburst   = hdr_q[BURST_LSB +: 2];
    assign awuser    = hdr_q[USER_LSB +: 2];

    // Current beat selection from the slot by the beat counter.
    assign last_beat = (cnt_q == slot_len);
    assign data_base = 32'(cnt_q) * 32'(DATA_WIDTH);
    assign strb_base = 32'(cnt_q) * 32'(STRB_W);
    assign wdata     = data_q[data_base +: DATA_WIDTH];
    assign wstrb     = strb_q[strb_base +: STRB_W];
    assign wlast     = wvalid_q & last_beat;

    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);
    assign ld_ready  = (state_q == S_IDLE);

    // Burst sequencer: load slot, issue AW, stream W beats, collect B.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hdr_q     <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            cnt_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // done/err are single-cycle pulses by default.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ld_valid) begin
                        hdr_q     <= ld_hdr;
                        data_q    <= ld_data;
                        strb_q    <= ld_strb;
                        cnt_q     <= '0;
                        awvalid_q <= 1'b1;
                        state_q   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (wready) begin
                        if (last_beat) begin
                            // Counter parks on the final beat index.
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state_q  <= S_RESP;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (bvalid) begin
                        bready_q <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= (bresp != 2'b00) || (bid != slot_id);
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/burst_initiator.md
BURST_INITIATOR -- requirements
Module: burst_initiator

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 4, meaning AXI write ID width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning beat data width; strobe width is DATA_WIDTH/8.
REQ-004 The block SHALL have parameter MAX_LEN, default 16, meaning maximum beats per burst, so awlen ranges 0..15.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port ld_valid, input, 1, meaning a burst slot is offered for transmission.
REQ-008 The block SHALL have port ld_ready, output, 1, meaning the slot is accepted this cycle.
REQ-009 The block SHALL have port ld_hdr, input, ID_WIDTH+ADDR_WIDTH+11, packed LSB-first as {user[1:0], burst[1:0], size[2:0], len[3:0], addr, id}.
REQ-010 The block SHALL have port ld_data, input, MAX_LEN*DATA_WIDTH; beat k occupies [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 The block SHALL have port ld_strb, input, MAX_LEN*DATA_WIDTH/8; beat k occupies [k*DATA_WIDTH/8 +: DATA_WIDTH/8].
REQ-012 The block SHALL have port awvalid, output, 1, AXI write-address valid.
REQ-013 The block SHALL have port awready, input, 1, AXI write-address ready.
REQ-014 The block SHALL have ports awid (ID_WIDTH), awaddr (ADDR_WIDTH), awlen (4), awsize (3), awburst (2) and awuser (2), all outputs carrying the captured header fields.
REQ-015 The block SHALL have port wvalid, output, 1, AXI write-data valid.
REQ-016 The block SHALL have port wready, input, 1, AXI write-data ready.
REQ-017 The block SHALL have ports wdata (DATA_WIDTH) and wstrb (DATA_WIDTH/8), outputs carrying the current beat's data and strobes.
REQ-018 The block SHALL have port wlast, output, 1, marking the final beat.
REQ-019 The block SHALL have port bvalid, input, 1, AXI write-response valid.
REQ-020 The block SHALL have port bready, output, 1, AXI write-response ready.
REQ-021 The block SHALL have ports bid (ID_WIDTH) and bresp (2), inputs carrying the response ID and status.
REQ-022 The block SHALL have port done, output, 1, a one-cycle pulse on burst completion.
REQ-023 The block SHALL have port err, output, 1, a one-cycle pulse, coincident with done, on a bad response.
REQ-024 The block SHALL have port busy, output, 1, asserted when state is not IDLE.

Function
REQ-025 The block SHALL implement FSM states IDLE, ADDR, DATA and RESP; transitions are IDLE->ADDR on load, ADDR->DATA on AW handshake, DATA->RESP on last W handshake, and RESP->IDLE on B handshake.
REQ-026 ld_ready SHALL equal (state==IDLE) combinationally; on ld_valid&ld_ready the header, data and strb SHALL be registered into an internal slot and the beat counter cleared.
REQ-027 ld_valid while busy SHALL be ignored with no side effects.
REQ-028 awvalid SHALL be high exactly in ADDR, starting the cycle after load; aw* fields SHALL come from the slot registers and stay stable until awvalid&awready.
REQ-029 wvalid SHALL be high exactly in DATA, with no W beat before the AW handshake; wdata/wstrb SHALL be slot beat[cnt], and wlast SHALL equal (cnt==awlen).
REQ-030 The 4-bit beat counter SHALL increment only on wvalid&wready, SHALL never exceed awlen, and SHALL hold its beat while wready is low.
REQ-031 With awready and wready tied high, a len=L burst SHALL emit AW in cycle N+1 after load in cycle N, and W beats in cycles N+2..N+2+L back-to-back.
REQ-032 bready SHALL be high exactly in RESP; bvalid outside RESP SHALL be ignored.
REQ-033 On bvalid&bready, done SHALL pulse the next cycle, with state IDLE and ld_ready=1 in that same cycle.
REQ-034 err SHALL pulse with done if bresp!=2'b00 or bid!=captured id; otherwise err=0.
REQ-035 awlen=0 SHALL produce a single beat with wlast=1.

Reset
REQ-036 While rst=1 at a clock edge, state SHALL go to IDLE; awvalid, wvalid, wlast, bready, done and err SHALL be 0; the counter and slot registers SHALL be 0; and busy SHALL be 0.
REQ-037 Reset asserted mid-burst SHALL abandon the burst, deasserting awvalid/wvalid at that edge with no done pulse; the first load after reset SHALL proceed normally.

Verification
REQ-038 A bench SHALL cover: load id=3, addr=0x1000, len=3, all ready high -> AW at N+1, 4 W beats at N+2..N+5 with wlast only at N+5, bvalid bid=3 bresp=0 -> done=1, err=0.
REQ-039 A bench SHALL cover: awready held low 5 cycles -> awvalid and aw* stable for 5 cycles, no wvalid until after the handshake.
REQ-040 A bench SHALL cover: wready toggling every other cycle, len=2 -> beats 0,1,2 each presented until accepted, in order, with no skips or duplicates.
REQ-041 A bench SHALL cover: bresp=2'b10, and separately bid=5 vs id=3 -> done=1 and err=1 in the same cycle.
REQ-042 A bench SHALL cover: ld_valid held during busy -> ld_ready=0 and the second slot is loaded only in the done cycle; len=0 -> a single beat with wlast=1.
REQ-043 A bench SHALL cover: rst pulsed during the DATA state -> outputs zero at the next edge, no done, and a following burst completes correctly.
